// File: rtl/ipm2l_hsstlp_rst_pkg.sv
// Shared definitions for the HSSTLP reset sequencers: PLL sequencer state
// encoding, per-state output decode and parameter helpers.
package ipm2l_hsstlp_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_PD    = 3'd1,
    ST_PLL_RST   = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_LOCK_DEB  = 3'd4,
    ST_DONE      = 3'd5
  } pll_state_e;

  typedef struct packed {
    logic pd_n;
    logic rst_n;
    logic clr;
    logic done;
  } pll_out_t;

  localparam pll_out_t PLL_OUT_RESET = '{pd_n: 1'b0, rst_n: 1'b0, clr: 1'b1, done: 1'b0};

  // Outputs are a pure function of state so they can be registered from the next state.
  function automatic pll_out_t pll_decode(input pll_state_e st);
    pll_out_t o;
    o = PLL_OUT_RESET;
    case (st)
      ST_IDLE:      o = PLL_OUT_RESET;
      ST_PLL_PD:    o = PLL_OUT_RESET;
      ST_PLL_RST:   o = '{pd_n: 1'b1, rst_n: 1'b0, clr: 1'b1, done: 1'b0};
      ST_WAIT_LOCK: o = '{pd_n: 1'b1, rst_n: 1'b1, clr: 1'b0, done: 1'b0};
      ST_LOCK_DEB:  o = '{pd_n: 1'b1, rst_n: 1'b1, clr: 1'b0, done: 1'b0};
      ST_DONE:      o = '{pd_n: 1'b1, rst_n: 1'b1, clr: 1'b0, done: 1'b1};
      default:      o = PLL_OUT_RESET;
    endcase
    return o;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

endpackage

// File: rtl/ipm2l_hsstlp_rst_sync.sv
// Two-flop synchronizer with a configurable reset value; shared by the
// HSSTLP reset stages.
module ipm2l_hsstlp_rst_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ipm2l_hsstlp_pll_rst_fsm.sv
// PLL reset sequencer: power-down, reset, debounced lock wait, and
// watchdog-driven restart of a PLL that fails to lock.
module ipm2l_hsstlp_pll_rst_fsm
  import ipm2l_hsstlp_rst_pkg::*;
#(
  parameter int PD_CYCLES       = 64,
  parameter int RST_CYCLES      = 32,
  parameter int LOCK_DEB_CYCLES = 256,
  parameter int RETRY_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seq_en,
  input  logic                   pll_lock,
  input  logic                   wtchdg_rst_n,
  output logic                   pll_pd_n,
  output logic                   pll_rst_n,
  output logic                   pll_ready,
  output logic                   wtchdg_clr,
  output logic                   wtchdg_in,
  output logic [RETRY_WIDTH-1:0] retry_cnt,
  output logic [2:0]             fsm_st
);

  localparam int MAX_CYC = max3(PD_CYCLES, RST_CYCLES, LOCK_DEB_CYCLES);
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] PD_LAST  = CW'(PD_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(LOCK_DEB_CYCLES - 1);

  pll_state_e      state;
  pll_state_e      nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            lock_s;
  logic            wd_fire;
  pll_out_t        out_nxt;

  ipm2l_hsstlp_rst_sync #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // The watchdog only matters while we are waiting on the PLL to lock.
  assign wd_fire = seq_en && !wtchdg_rst_n &&
                   ((state == ST_WAIT_LOCK) || (state == ST_LOCK_DEB));

  // Next-state selection: disable beats watchdog, watchdog beats lock events.
  always_comb begin
    nxt = state;
    if (!seq_en) begin
      nxt = ST_IDLE;
    end else if (wd_fire) begin
      nxt = ST_PLL_PD;
    end else begin
      case (state)
        ST_IDLE: nxt = ST_PLL_PD;
        ST_PLL_PD: begin
          if (cnt == PD_LAST) nxt = ST_PLL_RST;
          else                nxt = ST_PLL_PD;
        end
        ST_PLL_RST: begin
          if (cnt == RST_LAST) nxt = ST_WAIT_LOCK;
          else                 nxt = ST_PLL_RST;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) nxt = ST_LOCK_DEB;
          else        nxt = ST_WAIT_LOCK;
        end
        ST_LOCK_DEB: begin
          if (!lock_s)              nxt = ST_WAIT_LOCK;
          else if (cnt == DEB_LAST) nxt = ST_DONE;
          else                      nxt = ST_LOCK_DEB;
        end
        ST_DONE: begin
          if (!lock_s) nxt = ST_WAIT_LOCK;
          else         nxt = ST_DONE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // Shared duration counter: restarts on any state change, runs only in timed states.
  always_comb begin
    cnt_nxt = '0;
    if (nxt != state) begin
      cnt_nxt = '0;
    end else if ((state == ST_PLL_PD) || (state == ST_PLL_RST) || (state == ST_LOCK_DEB)) begin
      cnt_nxt = cnt + CW'(1);
    end else begin
      cnt_nxt = '0;
    end
  end

  // Output decode of the upcoming state keeps outputs aligned with fsm_st.
  always_comb begin
    out_nxt = pll_decode(nxt);
  end

  // State, counter, retry count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_pd_n   <= PLL_OUT_RESET.pd_n;
      pll_rst_n  <= PLL_OUT_RESET.rst_n;
      wtchdg_clr <= PLL_OUT_RESET.clr;
      wtchdg_in  <= PLL_OUT_RESET.done;
      pll_ready  <= PLL_OUT_RESET.done;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (wd_fire && (retry_cnt != {RETRY_WIDTH{1'b1}})) begin
        retry_cnt <= retry_cnt + RETRY_WIDTH'(1);
      end else begin
        retry_cnt <= retry_cnt;
      end
      pll_pd_n   <= out_nxt.pd_n;
      pll_rst_n  <= out_nxt.rst_n;
      wtchdg_clr <= out_nxt.clr;
      wtchdg_in  <= out_nxt.done;
      pll_ready  <= out_nxt.done;
    end
  end

  assign fsm_st = state;

endmodule

// File: tb/tb_ipm2l_hsstlp_pll_rst_fsm.sv
// Directed self-checking bench for the PLL reset sequencer (default parameters).
module tb_ipm2l_hsstlp_pll_rst_fsm;

  logic       clk;
  logic       rst;
  logic       seq_en;
  logic       pll_lock;
  logic       wtchdg_rst_n;
  logic       pll_pd_n;
  logic       pll_rst_n;
  logic       pll_ready;
  logic       wtchdg_clr;
  logic       wtchdg_in;
  logic [3:0] retry_cnt;
  logic [2:0] fsm_st;

  int checks;
  int errors;

  ipm2l_hsstlp_pll_rst_fsm #(
    .PD_CYCLES       (64),
    .RST_CYCLES      (32),
    .LOCK_DEB_CYCLES (256),
    .RETRY_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seq_en       (seq_en),
    .pll_lock     (pll_lock),
    .wtchdg_rst_n (wtchdg_rst_n),
    .pll_pd_n     (pll_pd_n),
    .pll_rst_n    (pll_rst_n),
    .pll_ready    (pll_ready),
    .wtchdg_clr   (wtchdg_clr),
    .wtchdg_in    (wtchdg_in),
    .retry_cnt    (retry_cnt),
    .fsm_st       (fsm_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc);
    int n;
    n = 0;
    while (fsm_st !== s && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (fsm_st !== s) begin
      errors++;
      $display("FAIL wait_state: fsm_st=%0d required %0d within %0d cycles", fsm_st, s, maxc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (fsm_st !== 3'd0 || pll_pd_n !== 1'b0 || pll_rst_n !== 1'b0 || pll_ready !== 1'b0 ||
        wtchdg_in !== 1'b0 || wtchdg_clr !== 1'b1 || retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL %s: st=%0d pd_n=%b rst_n=%b rdy=%b in=%b clr=%b retry=%0d required 0 0 0 0 0 1 0",
               tag, fsm_st, pll_pd_n, pll_rst_n, pll_ready, wtchdg_in, wtchdg_clr, retry_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; seq_en = 1'b0; pll_lock = 1'b0; wtchdg_rst_n = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset_values");
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (fsm_st !== 3'd0) begin
      errors++; $display("FAIL idle_hold: fsm_st=%0d required 0", fsm_st);
    end
  endtask

  task automatic count_pd_rst(input string tag);
    int n;
    n = 0;
    while (pll_pd_n === 1'b0 && n < 200) begin n++; tick(); end
    checks++;
    if (n != 64 || fsm_st !== 3'd2) begin
      errors++; $display("FAIL %s_pd_len: %0d cycles st=%0d required 64 st=2", tag, n, fsm_st);
    end
    n = 0;
    while (pll_rst_n === 1'b0 && n < 200) begin n++; tick(); end
    checks++;
    if (n != 32 || fsm_st !== 3'd3 || pll_pd_n !== 1'b1 || wtchdg_clr !== 1'b0) begin
      errors++;
      $display("FAIL %s_rst_len: %0d cycles st=%0d pd_n=%b clr=%b required 32 st=3 pd_n=1 clr=0",
               tag, n, fsm_st, pll_pd_n, wtchdg_clr);
    end
  endtask

  task automatic wait_ready(input string tag, input int expn);
    int n;
    n = 0;
    while (pll_ready !== 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (n != expn || wtchdg_in !== 1'b1 || fsm_st !== 3'd5) begin
      errors++;
      $display("FAIL %s: ready after %0d cycles in=%b st=%0d required %0d in=1 st=5",
               tag, n, wtchdg_in, fsm_st, expn);
    end
  endtask

  task automatic test_nominal();
    seq_en = 1'b1;
    tick();
    checks++;
    if (fsm_st !== 3'd1 || pll_pd_n !== 1'b0 || wtchdg_clr !== 1'b1) begin
      errors++; $display("FAIL enter_pd: st=%0d pd_n=%b clr=%b required 1 0 1", fsm_st, pll_pd_n, wtchdg_clr);
    end
    count_pd_rst("nominal");
    repeat (9) tick();
    pll_lock = 1'b1;
    wait_ready("nominal_lock_latency", 259);
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b0;
    repeat (2) tick();
    checks++;
    if (pll_ready !== 1'b1) begin
      errors++; $display("FAIL loss_early: pll_ready=%b required 1", pll_ready);
    end
    tick();
    checks++;
    if (pll_ready !== 1'b0 || wtchdg_in !== 1'b0 || fsm_st !== 3'd3 || pll_pd_n !== 1'b1) begin
      errors++;
      $display("FAIL loss_3cyc: rdy=%b in=%b st=%0d pd_n=%b required 0 0 3 1",
               pll_ready, wtchdg_in, fsm_st, pll_pd_n);
    end
  endtask

  task automatic test_glitch();
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (fsm_st !== 3'd4 && n < 20) begin tick(); n++; end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL relock_to_deb: %0d cycles required 3", n);
    end
    repeat (200) tick();
    checks++;
    if (fsm_st !== 3'd4 || pll_ready !== 1'b0) begin
      errors++; $display("FAIL deb_midway: st=%0d rdy=%b required 4 0", fsm_st, pll_ready);
    end
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    tick();
    checks++;
    if (fsm_st !== 3'd3) begin
      errors++; $display("FAIL glitch_wait: st=%0d required 3", fsm_st);
    end
    tick();
    checks++;
    if (fsm_st !== 3'd4) begin
      errors++; $display("FAIL glitch_redeb: st=%0d required 4", fsm_st);
    end
    wait_ready("glitch_deb_len", 256);
  endtask

  task automatic test_watchdog();
    logic [3:0] expr;
    pll_lock = 1'b0;
    repeat (3) tick();
    checks++;
    if (fsm_st !== 3'd3) begin
      errors++; $display("FAIL wd_pre: st=%0d required 3", fsm_st);
    end
    wtchdg_rst_n = 1'b0;
    tick();
    checks++;
    if (fsm_st !== 3'd1 || pll_pd_n !== 1'b0 || wtchdg_clr !== 1'b1 || retry_cnt !== 4'd1) begin
      errors++;
      $display("FAIL wd_restart: st=%0d pd_n=%b clr=%b retry=%0d required 1 0 1 1",
               fsm_st, pll_pd_n, wtchdg_clr, retry_cnt);
    end
    tick();
    checks++;
    if (fsm_st !== 3'd1 || retry_cnt !== 4'd1) begin
      errors++; $display("FAIL wd_long_low: st=%0d retry=%0d required 1 1", fsm_st, retry_cnt);
    end
    wtchdg_rst_n = 1'b1;
    for (int i = 2; i <= 18; i++) begin
      wait_state(3'd3, 200);
      wtchdg_rst_n = 1'b0;
      tick();
      wtchdg_rst_n = 1'b1;
      expr = (i > 15) ? 4'd15 : 4'(i);
      checks++;
      if (fsm_st !== 3'd1 || retry_cnt !== expr) begin
        errors++;
        $display("FAIL wd_pulse_%0d: st=%0d retry=%0d required 1 %0d", i, fsm_st, retry_cnt, expr);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_state(3'd2, 200);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset_mid");
    tick();
    checks++;
    if (fsm_st !== 3'd1 || pll_pd_n !== 1'b0) begin
      errors++; $display("FAIL restart_pd: st=%0d pd_n=%b required 1 0", fsm_st, pll_pd_n);
    end
    count_pd_rst("restart");
  endtask

  task automatic test_priority();
    pll_lock = 1'b1;
    wait_state(3'd4, 20);
    repeat (5) tick();
    seq_en = 1'b0;
    wtchdg_rst_n = 1'b0;
    tick();
    checks++;
    if (fsm_st !== 3'd0 || retry_cnt !== 4'd0 || pll_pd_n !== 1'b0 || pll_ready !== 1'b0) begin
      errors++;
      $display("FAIL priority: st=%0d retry=%0d pd_n=%b rdy=%b required 0 0 0 0",
               fsm_st, retry_cnt, pll_pd_n, pll_ready);
    end
    wtchdg_rst_n = 1'b1;
    tick();
    checks++;
    if (fsm_st !== 3'd0) begin
      errors++; $display("FAIL priority_idle: st=%0d required 0", fsm_st);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; seq_en = 1'b0; pll_lock = 1'b0; wtchdg_rst_n = 1'b1;
    test_reset();
    test_nominal();
    test_lock_loss();
    test_glitch();
    test_watchdog();
    test_reset_mid();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
